sys_arr_feed_ctrl: RTL
======================

Name: sys_arr_feed_ctrl

Overview:
- Sequences the N row-input FIFOs of the systolic array.
- Accepts one matrix row per handshake and loads it into the FIFO for that row.
- After N rows, runs a skewed feed phase: FIFO i starts shifting i cycles after FIFO 0, forming the diagonal wavefront the array expects.
- Sits between the tile loader (row producer) and the N FIFO instances. It drives their load, shift and load_values inputs.

Parameters:
- N, 4, array dimension: number of FIFOs, rows per tile, elements per row.
- DW, 16, element data width in bits.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- row_valid  input  1  producer has a row on row_data
- row_ready  output  1  controller accepts a row this cycle
- row_data  input  DW*N  one matrix row, element 0 in bits [DW-1:0]
- array_stall  input  1  array cannot consume; freezes feed phase
- fifo_load  output  N  one-hot load strobe, bit r to FIFO r
- fifo_load_values  output  DW*N  row data broadcast to all FIFOs
- fifo_shift  output  N  per-FIFO shift strobe
- busy  output  1  high in FEED and DONE
- tile_done  output  1  one-cycle pulse at end of feed

Behaviour:
- States: LOAD, FEED, DONE. rst forces LOAD, row_cnt=0, feed_cnt=0.
- Counter widths: row_cnt is clog2(N) bits; feed_cnt is clog2(2N) bits.
- Reset values: all outputs 0, including row_ready during rst. Registered outputs clear on the cycle after rst is sampled high.
- Reset mid-operation (any state): same as power-on reset. The partial tile is discarded and no tile_done is issued.

LOAD state:
- row_ready=1 (combinational from state).
- Accept occurs when row_valid && row_ready at cycle t.
- At t+1 (registered): fifo_load = one-hot(row_cnt) and fifo_load_values = row_data.
- row_cnt increments on each accept.
- fifo_load is 0 in any cycle following a non-accept.
- array_stall is ignored in LOAD.
- On the accept with row_cnt==N-1: row_cnt wraps to 0 and the state moves to FEED at t+1 with feed_cnt=0. fifo_load[N-1] pulses in that same cycle; this is legal because the load and shift target distinct FIFOs.

FEED state:
- row_ready=0; row_valid is ignored and no load occurs.
- fifo_shift[i] = !array_stall && (i <= feed_cnt) && (feed_cnt < i+N). This is combinational from feed_cnt and array_stall.
- feed_cnt increments only when !array_stall.
- When feed_cnt==2N-2 and !array_stall, the next state is DONE.
- Each FIFO receives exactly N shifts per tile, regardless of stalls.

DONE state:
- Lasts one cycle.
- tile_done=1, fifo_shift=0, row_ready=0.
- Next state is LOAD.

Other rules:
- busy=1 in FEED and DONE.
- Feed latency for an unstalled tile is 2N-1 cycles; tile_done follows at cycle 2N.
- Minimum tile period is N accept cycles + 2N-1 feed cycles + 1 DONE cycle.

Optional Feature:
- Macro: SYS_ARR_FEED_PERF_EN.
- With the macro defined:
  - Adds output port stall_cycles (32 bits).
  - It counts cycles in FEED with array_stall=1, saturating at all-ones.
  - It clears to 0 on rst and on the cycle the state enters FEED.
  - It holds its value through DONE and LOAD until the next FEED entry.
- Without the macro: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: assert rst 2 cycles with row_valid=1 -> fifo_load=0, fifo_shift=0, row_ready=0, busy=0, tile_done=0 throughout reset. The cycle after release: row_ready=1.
- Load plus unstalled feed, N=4: present rows 0x1111.., 0x2222.., 0x3333.., 0x4444.. back-to-back from cycle t ->
  - fifo_load is 0001, 0010, 0100, 1000 at t+1..t+4, with matching fifo_load_values.
  - fifo_shift from t+4 is 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - tile_done=1 at t+11; row_ready=1 at t+12.
- Stall: 3-cycle array_stall while feed_cnt=2 -> fifo_shift=0000 for those 3 cycles, then resumes at 0111. tile_done is delayed by exactly 3 cycles, and each FIFO still receives 4 shifts.
- Backpressure: hold row_valid=1 during FEED and DONE -> row_ready=0 and no fifo_load pulse. The next row is accepted the cycle after DONE.
- Gapped load: insert 2 idle cycles between rows 1 and 2 -> fifo_load=0000 in the gap cycles, and row_cnt is preserved. FEED starts the cycle after the row-3 accept.
- Reset mid-feed at feed_cnt=3, then with SYS_ARR_FEED_PERF_EN defined ->
  - After the reset: outputs are 0, state is LOAD, and no tile_done is issued.
  - A following tile with 3 stall cycles shows stall_cycles=3 at tile_done.

Source files
------------

// File: rtl/sys_arr_feed_ctrl.sv
// -----------------------------------------------------------------------------
// sys_arr_feed_ctrl
//
// Purpose:
//   Sequences the N row-input FIFOs of a systolic array. In LOAD it accepts
//   one matrix row per valid/ready handshake and loads it into the FIFO for
//   that row. After N rows it runs a skewed FEED phase in which FIFO i starts
//   shifting i cycles after FIFO 0. This forms the diagonal wavefront the
//   array expects. A single DONE cycle then pulses tile_done.
//
// Parameters:
//   N   array dimension (FIFOs, rows per tile, elements per row)
//   DW  element width in bits
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   row_valid         producer presents a row on row_data
//   row_ready         row accepted this cycle (LOAD state only)
//   row_data          one row, element 0 in bits [DW-1:0]
//   array_stall       array cannot consume; freezes the feed phase
//   fifo_load         registered one-hot load strobe, bit r -> FIFO r
//   fifo_load_values  registered row data broadcast to all FIFOs
//   fifo_shift        per-FIFO shift strobe (combinational)
//   busy              high in FEED and DONE
//   tile_done         one-cycle pulse at the end of the feed phase
//   stall_cycles      (SYS_ARR_FEED_PERF_EN only) stalled FEED cycles of
//                     the current/last tile, saturating
//
// Build option:
//   `define SYS_ARR_FEED_PERF_EN adds the stall_cycles performance counter.
// -----------------------------------------------------------------------------
module sys_arr_feed_ctrl #(
    parameter int N  = 4,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            row_valid,
    output logic            row_ready,
    input  logic [DW*N-1:0] row_data,
    input  logic            array_stall,
    output logic [N-1:0]    fifo_load,
    output logic [DW*N-1:0] fifo_load_values,
    output logic [N-1:0]    fifo_shift,
    output logic            busy,
    output logic            tile_done
`ifdef SYS_ARR_FEED_PERF_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    localparam int RCW = (N > 1) ? $clog2(N) : 1;
    localparam int FCW = $clog2(2 * N);

    localparam logic [RCW-1:0] LAST_ROW  = RCW'(N - 1);
    localparam logic [FCW-1:0] FEED_LAST = FCW'(2 * N - 2);
    localparam logic [N-1:0]   ONE_HOT0  = N'(1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FEED,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [RCW-1:0]    row_cnt_q, row_cnt_d;
    logic [FCW-1:0]    feed_cnt_q, feed_cnt_d;
    logic [N-1:0]      fifo_load_q, fifo_load_d;
    logic [DW*N-1:0]   load_values_q, load_values_d;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        feed_cnt_d    = feed_cnt_q;
        fifo_load_d   = '0;
        load_values_d = load_values_q;
        row_ready     = 1'b0;
        fifo_shift    = '0;
        busy          = 1'b0;
        tile_done     = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                row_ready = 1'b1;
                if (row_valid) begin
                    fifo_load_d   = ONE_HOT0 << row_cnt_q;
                    load_values_d = row_data;
                    if (row_cnt_q == LAST_ROW) begin
                        row_cnt_d  = '0;
                        feed_cnt_d = '0;
                        state_d    = ST_FEED;
                    end else begin
                        row_cnt_d = row_cnt_q + RCW'(1);
                    end
                end
            end

            ST_FEED: begin
                busy = 1'b1;
                if (!array_stall) begin
                    // FIFO i is active for the N feed steps starting at step i,
                    // which produces the diagonal wavefront.
                    for (int i = 0; i < N; i++) begin
                        fifo_shift[i] = (int'(feed_cnt_q) >= i) &&
                                        (int'(feed_cnt_q) < i + N);
                    end
                    if (feed_cnt_q == FEED_LAST) begin
                        feed_cnt_d = '0;
                        state_d    = ST_DONE;
                    end else begin
                        feed_cnt_d = feed_cnt_q + FCW'(1);
                    end
                end
            end

            ST_DONE: begin
                busy      = 1'b1;
                tile_done = 1'b1;
                state_d   = ST_LOAD;
            end

            default: state_d = ST_LOAD;
        endcase

        // State-decoded outputs read as zero while reset is held. This also
        // blocks any handshake during reset.
        if (rst) begin
            row_ready  = 1'b0;
            fifo_shift = '0;
            busy       = 1'b0;
            tile_done  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the
        // pre-edge value of the others, independent of statement order.
        if (rst) begin
            state_q       <= ST_LOAD;
            row_cnt_q     <= '0;
            feed_cnt_q    <= '0;
            fifo_load_q   <= '0;
            load_values_q <= '0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            feed_cnt_q    <= feed_cnt_d;
            fifo_load_q   <= fifo_load_d;
            load_values_q <= load_values_d;
        end
    end

    assign fifo_load        = fifo_load_q;
    assign fifo_load_values = load_values_q;

`ifdef SYS_ARR_FEED_PERF_EN
    // -------------------------------------------------------------------------
    // Stall counter: cleared on FEED entry and held afterwards, so software can
    // read the previous tile's figure while the next tile loads.
    // -------------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_LOAD && state_d == ST_FEED) begin
            stall_cnt_d = '0;
        end else if (state_q == ST_FEED && array_stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule
